// File: rtl/pnu_pkg.sv
// Shared constants and types for the serial window loader feeding the 8-input
// AND reduction stage.
package pnu_pkg;

  localparam int WIN_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0] DROP_MAX = 4'd15;

endpackage

// File: rtl/serial_window_loader_sat_cnt4.sv
// 4-bit saturating counter. An increment in the same cycle as a clear
// restarts the count at 1, so the coinciding event is not lost.
module sat_cnt4
  import pnu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (inc) begin
      if (clr) begin
        cnt <= 4'd1;
      end else if (cnt != DROP_MAX) begin
        cnt <= cnt + 4'd1;
      end
    end else if (clr) begin
      cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/serial_window_loader.sv
// Assembles an LSB-first serial bit stream into a window for the AND reduction
// stage and holds each completed window until the consumer takes it.
module serial_window_loader
  import pnu_pkg::*;
#(
  parameter int WIDTH = WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             flush,
  input  logic             win_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] win,
  output logic             win_valid,
  output logic [2:0]       bit_cnt,
  output logic             overrun,
  output logic [3:0]       drop_cnt,
  output state_t           state_dbg
);

  // Handshake: a window transfers on a rising edge where win_valid && win_ready.
  // Once raised, win_valid stays high and win stays frozen until that transfer;
  // only flush or rst may withdraw it. win_ready is ignored while win_valid=0.

  state_t           state_q, state_n;
  logic [WIDTH-1:0] win_q, win_n;
  logic [2:0]       cnt_q, cnt_n;
  logic             ovr_q, ovr_n;
  logic             drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      win_q   <= '0;
      cnt_q   <= 3'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      win_q   <= win_n;
      cnt_q   <= cnt_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    win_n   = win_q;
    cnt_n   = cnt_q;
    drop    = 1'b0;

    if (flush) begin
      // A bit arriving with flush is discarded, not dropped.
      state_n = FILL;
      win_n   = '0;
      cnt_n   = 3'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (bit_valid) begin
            win_n[cnt_q] = bit_in;
            cnt_n        = cnt_q + 3'd1;
            if (cnt_q == 3'(WIDTH - 1)) begin
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (win_ready) begin
            // The new window starts cleared; a coinciding bit becomes bit 0.
            state_n = FILL;
            win_n   = '0;
            if (bit_valid) begin
              win_n[0] = bit_in;
              cnt_n    = 3'd1;
            end
          end else if (bit_valid) begin
            drop = 1'b1;
          end
        end
        default: begin
          state_n = FILL;
          win_n   = '0;
          cnt_n   = 3'd0;
        end
      endcase
    end

    ovr_n = ovr_q;
    if (drop) begin
      ovr_n = 1'b1;
    end else if (clr_ovr) begin
      ovr_n = 1'b0;
    end
  end

  sat_cnt4 u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .clr (clr_ovr),
    .cnt (drop_cnt)
  );

  assign win       = win_q;
  assign win_valid = (state_q == HOLD);
  assign bit_cnt   = cnt_q;
  assign overrun   = ovr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_window_loader.sv
// Directed bench for serial_window_loader: a vector table for the single-cycle
// behaviour plus hand-written sequences for throughput, saturation and reset.
module tb_serial_window_loader;
  import pnu_pkg::*;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic       win_ready;
  logic       clr_ovr;
  logic [7:0] win;
  logic       win_valid;
  logic [2:0] bit_cnt;
  logic       overrun;
  logic [3:0] drop_cnt;
  state_t     state_dbg;

  int total;
  int bad;

  typedef struct {
    logic       bi;
    logic       bv;
    logic       fl;
    logic       wr;
    logic       co;
    logic [7:0] w;
    logic       wv;
    logic [2:0] bc;
    logic       ov;
    logic [3:0] dc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  serial_window_loader #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .flush     (flush),
    .win_ready (win_ready),
    .clr_ovr   (clr_ovr),
    .win       (win),
    .win_valid (win_valid),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun),
    .drop_cnt  (drop_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic bi, input logic bv, input logic fl, input logic wr,
                              input logic co, input logic [7:0] w, input logic wv,
                              input logic [2:0] bc, input logic ov, input logic [3:0] dc);
    vec_t v;
    v.bi = bi; v.bv = bv; v.fl = fl; v.wr = wr; v.co = co;
    v.w  = w;  v.wv = wv; v.bc = bc; v.ov = ov; v.dc = dc;
    vecs.push_back(v);
  endfunction

  // Eight bits from pattern (LSB first), no ready; expected window accumulates.
  function automatic void add_fill(input logic [7:0] pattern, input logic ov, input logic [3:0] dc);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc[i] = pattern[i];
      add(pattern[i], 1'b1, 1'b0, 1'b0, 1'b0, acc, (i == 7), 3'((i + 1) % 8), ov, dc);
    end
  endfunction

  // driver
  task automatic drive(input logic bi, input logic bv, input logic fl, input logic wr, input logic co);
    @(negedge clk);
    bit_in    = bi;
    bit_valid = bv;
    flush     = fl;
    win_ready = wr;
    clr_ovr   = co;
  endtask

  task automatic check_all(input string tag, input logic [7:0] w, input logic wv,
                           input logic [2:0] bc, input logic ov, input logic [3:0] dc);
    check({tag, ".win"}, 32'(win), 32'(w));
    check({tag, ".win_valid"}, 32'(win_valid), 32'(wv));
    check({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(bc));
    check({tag, ".overrun"}, 32'(overrun), 32'(ov));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(dc));
  endtask

  initial begin
    logic [7:0] acc;
    logic       b;

    total = 0;
    bad   = 0;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; win_ready = 1'b0; clr_ovr = 1'b0;
    #12;
    check_all("reset", 8'h00, 1'b0, 3'd0, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // all ones, then accept
    add_fill(8'hFF, 1'b0, 4'd0);
    add(0, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0, 4'd0);
    // 1,0,1,1,1,1,1,1 LSB first
    add_fill(8'hFD, 1'b0, 4'd0);
    // three drops while held, then clear
    add(1, 1, 0, 0, 0, 8'hFD, 1, 3'd0, 1, 4'd1);
    add(0, 1, 0, 0, 0, 8'hFD, 1, 3'd0, 1, 4'd2);
    add(1, 1, 0, 0, 0, 8'hFD, 1, 3'd0, 1, 4'd3);
    add(0, 0, 0, 0, 1, 8'hFD, 1, 3'd0, 0, 4'd0);
    // ready with coinciding bit: becomes bit 0 of the next window
    add(1, 1, 0, 1, 0, 8'h01, 0, 3'd1, 0, 4'd0);
    add(0, 1, 0, 0, 0, 8'h01, 0, 3'd2, 0, 4'd0);
    add(1, 1, 0, 0, 0, 8'h05, 0, 3'd3, 0, 4'd0);
    add(0, 1, 0, 0, 0, 8'h05, 0, 3'd4, 0, 4'd0);
    add(1, 1, 0, 0, 0, 8'h15, 0, 3'd5, 0, 4'd0);
    // flush with a concurrent bit: discarded, no drop
    add(1, 1, 1, 0, 0, 8'h00, 0, 3'd0, 0, 4'd0);
    add_fill(8'h00, 1'b0, 4'd0);
    // drop, drop, then drop together with clear: drop wins
    add(1, 1, 0, 0, 0, 8'h00, 1, 3'd0, 1, 4'd1);
    add(1, 1, 0, 0, 0, 8'h00, 1, 3'd0, 1, 4'd2);
    add(1, 1, 0, 0, 1, 8'h00, 1, 3'd0, 1, 4'd1);
    // flush in HOLD keeps overrun state
    add(0, 0, 1, 0, 0, 8'h00, 0, 3'd0, 1, 4'd1);
    add(1, 1, 0, 1, 1, 8'h01, 0, 3'd1, 0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].bi, vecs[i].bv, vecs[i].fl, vecs[i].wr, vecs[i].co);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].w, vecs[i].wv, vecs[i].bc, vecs[i].ov, vecs[i].dc);
      if (i == 7) check("and_out_ones", 32'(&win), 32'd1);
    end

    // back-to-back windows with ready held high: one window per 8 cycles, no drops
    drive(0, 0, 1, 0, 1);
    acc = 8'h00;
    for (int i = 0; i < 24; i++) begin
      b = 1'($urandom_range(0, 1));
      drive(b, 1'b1, 1'b0, 1'b1, 1'b0);
      acc[i % 8] = b;
      if (i % 8 == 7) begin
        exp_q.push_back(acc);
        acc = 8'h00;
      end
      @(posedge clk);
      #1;
      check($sformatf("tput%0d.win_valid", i), 32'(win_valid), 32'(i % 8 == 7));
      if (win_valid) begin
        if (exp_q.size() == 0) check($sformatf("tput%0d.unexpected", i), 32'd1, 32'd0);
        else check($sformatf("tput%0d.win", i), 32'(win), 32'(exp_q.pop_front()));
      end
    end
    check("tput.drop_cnt", 32'(drop_cnt), 32'd0);
    check("tput.leftover", 32'(exp_q.size()), 32'd0);

    // saturation of the drop counter
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d.drop_cnt", k), 32'(drop_cnt), 32'((k > 15) ? 15 : k));
    end
    check_all("sat.end", 8'hFF, 1'b1, 3'd0, 1'b1, 4'd15);

    // asynchronous reset in the middle of a window
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("pre_rst", 8'h0F, 1'b0, 3'd4, 1'b1, 4'd15);
    @(negedge clk);
    bit_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 1'b0, 3'd0, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_window_loader.md
# serial_window_loader

Upstream feeder for the 8-input AND reduction stage (`multiAND`). Collects a serial bit stream into an 8-bit window, LSB-first, and holds the completed window on `win` until the consumer accepts it. Once accepted, it starts the next window. Bits that arrive while a full window is held are counted as lost and flagged. The block supplies the `in[7:0]` bus of the reduction stage.

## Interface
Parameters:
- `WIDTH`, 8, window width. Must equal the reduction stage input width; only 8 is supported.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `bit_in`  input  1  serial data bit.
- `bit_valid`  input  1  `bit_in` is valid this cycle.
- `flush`  input  1  synchronous; discards the partial window, returns to FILL.
- `win_ready`  input  1  consumer accepts `win` this cycle.
- `clr_ovr`  input  1  synchronous clear of `overrun` and `drop_cnt`.
- `win`  output  WIDTH  assembled window, connects to the `in` bus of the reduction stage.
- `win_valid`  output  1  `win` holds a complete window.
- `bit_cnt`  output  3  bits collected in the current window (0..7).
- `overrun`  output  1  sticky; a valid bit was dropped.
- `drop_cnt`  output  4  dropped-bit count; saturates at 15.

## Operation
States:
- **FILL**: collecting bits.
  - If `bit_valid`: `win[bit_cnt] <= bit_in`, and `bit_cnt` increments.
  - When the 8th bit is accepted (`bit_cnt`==7 with `bit_valid`): go to HOLD, `bit_cnt` wraps to 0, `win_valid`=1 from the next cycle.
- **HOLD**: `win` is frozen and `win_valid`=1.
  - If `win_ready`: go to FILL and drop `win_valid`.
  - If `bit_valid` coincides with `win_ready`: the bit is accepted as bit 0 of the next window, `bit_cnt` becomes 1, and nothing is counted as dropped.
  - If `bit_valid` arrives without `win_ready`: the bit is dropped, `overrun` is set to 1, and `drop_cnt` increments, saturating at 15.

Window contents:
- Unfilled bits of a new window read 0. `win` is cleared to 0 on entering FILL from HOLD or on `flush`; the cleared value is then overwritten as bits arrive.
- The consumer sees `win` only while `win_valid`=1. The AND output is meaningful only then.

`flush` (highest priority after reset):
- In either state: `bit_cnt`=0, `win`=0, `win_valid`=0, state becomes FILL.
- `bit_valid` in the same cycle is ignored and not counted as dropped.
- `overrun` and `drop_cnt` are unaffected.

`clr_ovr`:
- Clears `overrun` and `drop_cnt`.
- If a drop happens in the same cycle, the drop wins: `overrun`=1 and `drop_cnt`=1.

Precedence per cycle: `rst` > `flush` > `win_ready`/`bit_valid` > `clr_ovr`.

## Timing
- Reset values: state FILL, `win`=0, `win_valid`=0, `bit_cnt`=0, `overrun`=0, `drop_cnt`=0. Reset acts asynchronously and may hit mid-window or during HOLD; the partial or held window is lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Fill latency: with `bit_valid` high for 8 consecutive cycles starting at edge k, `win_valid`=1 after edge k+7.
- Handshake: a transfer occurs on a rising edge where `win_valid` && `win_ready`.
  - `win_valid` never drops without a transfer, except on `flush` or `rst`.
  - `win` is stable while `win_valid`=1.
- Peak throughput: one window every 8 cycles, with no dropped bits if `win_ready` is held at 1.

## Structure
- Shared package `pnu_pkg`:
  - `WIN_W` = 8.
  - State enum: FILL=1'b0, HOLD=1'b1.
  - `DROP_MAX` = 4'd15.
- One sub-module, `sat_cnt4`: 4-bit saturating counter with inc and clr. Used for `drop_cnt`.
- Everything else lives in `serial_window_loader`.

## Test plan
- Reset, then bits 1,1,1,1,1,1,1,1 with `win_ready`=0 -> `win`=8'hFF, `win_valid`=1 after the 8th edge, downstream `out`=1.
- Bits 1,0,1,1,1,1,1,1 (LSB first) -> `win`=8'hFD; after `win_ready`, `win_valid`=0 and `win`=0.
- Full window held and 3 extra `bit_valid` pulses with `win_ready`=0 -> `overrun`=1, `drop_cnt`=3, `win` unchanged. Then `clr_ovr` -> both 0.
- HOLD with `win_ready` and `bit_valid` (`bit_in`=1) in the same cycle -> next cycle `win_valid`=0, `win`=8'h01, `bit_cnt`=1, `drop_cnt` unchanged.
- 5 bits, then `flush` concurrent with `bit_valid` -> `bit_cnt`=0, `win`=0, no drop. Then 8 bits of 0 -> `win`=8'h00, `win_valid`=1.
- 20 drops -> `drop_cnt` saturates at 15. Assert `rst` mid-window (`bit_cnt`=4) -> all outputs return to reset values immediately, without waiting for `clk`.
